mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ALUOP_W SHALL default to 5 and set the width of ALUOp.
REQ-002 Parameter DMTYPE_W SHALL default to 3 and set the width of DMType.
REQ-003 Port clk  in  1 SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  in  1 SHALL be the reset: asynchronous, active-high.
REQ-005 Ports Op in 7, Funct3 in 3, Funct7 in 7 SHALL carry the instruction-register fields, stable from DECODE to instruction end.
REQ-006 Ports Zero in 1 (ALU result==0) and mem_ready in 1 (memory access completes this cycle) SHALL be status inputs.
REQ-007 Outputs PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc, retire, illegal SHALL each be 1 bit.
REQ-008 Outputs ALUOp [ALUOP_W], EXTOp 3, NPCOp 3, DMType [DMTYPE_W], WDSel 2, state 3 SHALL be buses.

Function
REQ-009 The states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-010 FETCH: MemRead=1 and IRWrite=mem_ready; hold FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-011 DECODE: no enables asserted; go to EXEC, or to HALT when the opcode is illegal and CTRL_ILLEGAL_EN is defined.
REQ-012 EXEC with R (0110011), I-ALU (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111) or JALR (1100111): go to WB.
REQ-013 EXEC with load (0000011) or store (0100011): ALUOp=add, ALUSrc=1; go to MEM.
REQ-014 EXEC with branch (1100011): ALUOp=sub for beq/bne and slt/sltu for blt,bge/bltu,bgeu; PCWrite=1; go to FETCH.
REQ-015 Branch taken SHALL be: beq Zero; bne ~Zero; blt/bltu ~Zero; bge/bgeu Zero. NPCOp SHALL be 001 when taken, else 000.
REQ-016 MEM load: MemRead=1 and DMType valid; hold until mem_ready; then go to WB.
REQ-017 MEM store: MemWrite=1 and DMType valid; hold until mem_ready; on mem_ready assert PCWrite=1, NPCOp=000 and retire=1, then go to FETCH.
REQ-018 WB: RegWrite=1 and PCWrite=1; go to FETCH.
REQ-019 WB NPCOp SHALL be 010 for JAL, 100 for JALR, else 000.
REQ-020 WB WDSel SHALL be 01 for load, 10 for JAL/JALR, else 00.
REQ-021 PCWrite SHALL pulse exactly once per instruction, in its final cycle.
REQ-022 retire SHALL equal PCWrite.
REQ-023 ALUOp encodings SHALL be: nop 00000, lui 00001, auipc 00010, add 00011, sub 00100, sll 00101, slt 00110, sltu 00111, xor 01000, srl 01001, sra 01010, or 01011, and 01100; the value is zero-extended to ALUOP_W.
REQ-024 R-type and I-ALU SHALL decode ALUOp from Funct3/Funct7[5]; Funct7[5] selects sra/sub and is ignored for I-type except srai.
REQ-025 DMType SHALL be word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100.
REQ-026 EXTOp SHALL be I 001, S 010, B 011, U 100, J 101, none 000.
REQ-027 ALUSrc SHALL be 1 for I-ALU, load, store and JALR.
REQ-028 With mem_ready=1, latencies SHALL be: branch 3 cycles, store 4, ALU/jump 4, load 5.
REQ-029 An instruction that loses mem_ready SHALL stall indefinitely in FETCH or MEM with outputs held.

Reset
REQ-030 While rst=1, state SHALL be FETCH and every output SHALL be 0, including MemRead.
REQ-031 Reset asserted mid-instruction SHALL abort it with no further PCWrite, RegWrite or MemWrite.
REQ-032 After reset deasserts, the first fetch SHALL begin on the next clock.

Configuration
REQ-033 With CTRL_ILLEGAL_EN defined, an unlisted opcode in DECODE SHALL enter HALT.
REQ-034 In HALT, illegal SHALL be 1 and sticky, all enables SHALL be 0, and only rst SHALL exit HALT.
REQ-035 Without CTRL_ILLEGAL_EN, an unlisted opcode SHALL go DECODE->EXEC with PCWrite=1, NPCOp=000, no other enable, then FETCH; illegal SHALL be tied 0 and HALT SHALL be unreachable.

Verification
REQ-036 add x3,x1,x2 with mem_ready=1: states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=00011; WDSel=00.
REQ-037 lw with mem_ready low 2 cycles in MEM: the instruction takes 7 cycles; DMType=000; WDSel=01; one retire pulse.
REQ-038 bne with Zero=0: EXEC has PCWrite=1 and NPCOp=001; bge with Zero=0 gives NPCOp=000.
REQ-039 sb then jalr: sb has MemWrite with DMType=011 and goes MEM->FETCH; jalr WB has WDSel=10 and NPCOp=100.
REQ-040 Op=1111111 with CTRL_ILLEGAL_EN: state 5 and illegal=1 held for 10 cycles; rst pulse returns state 0 and illegal=0; rst asserted during load MEM produces no RegWrite.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) driving datapath enables and selects.
// Optional CTRL_ILLEGAL_EN: unlisted opcodes enter a sticky HALT instead of retiring as a no-op.
module mc_ctrl #(
  parameter int ALUOP_W  = 5,
  parameter int DMTYPE_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          Op,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic                retire,
  output logic                illegal,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [2:0]          EXTOp,
  output logic [2:0]          NPCOp,
  output logic [DMTYPE_W-1:0] DMType,
  output logic [1:0]          WDSel,
  output logic [2:0]          state
);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  localparam logic [4:0] A_NOP = 5'd0, A_LUI = 5'd1, A_AUIPC = 5'd2, A_ADD = 5'd3,
                         A_SUB = 5'd4, A_SLL = 5'd5, A_SLT = 5'd6, A_SLTU = 5'd7,
                         A_XOR = 5'd8, A_SRL = 5'd9, A_SRA = 5'd10, A_OR = 5'd11,
                         A_AND = 5'd12;

  logic [2:0] state_q, state_d;

  logic       is_r, is_ialu, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_load, is_store, is_branch, is_legal;
  logic [4:0] alu_op;
  logic [2:0] ext_op;
  logic [2:0] dm_type;
  logic       alu_src;
  logic       br_taken;

  logic unused_funct7;
  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

  function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_f3 = alt ? A_SUB : A_ADD;
      3'b001:  alu_f3 = A_SLL;
      3'b010:  alu_f3 = A_SLT;
      3'b011:  alu_f3 = A_SLTU;
      3'b100:  alu_f3 = A_XOR;
      3'b101:  alu_f3 = alt ? A_SRA : A_SRL;
      3'b110:  alu_f3 = A_OR;
      default: alu_f3 = A_AND;
    endcase
  endfunction

  always_comb begin
    is_r      = (Op == 7'b0110011);
    is_ialu   = (Op == 7'b0010011);
    is_lui    = (Op == 7'b0110111);
    is_auipc  = (Op == 7'b0010111);
    is_jal    = (Op == 7'b1101111);
    is_jalr   = (Op == 7'b1100111);
    is_load   = (Op == 7'b0000011);
    is_store  = (Op == 7'b0100011);
    is_branch = (Op == 7'b1100011);
    is_legal  = is_r | is_ialu | is_lui | is_auipc | is_jal | is_jalr |
                is_load | is_store | is_branch;

    alu_op = A_NOP;
    ext_op = 3'b000;
    if (is_r) begin
      alu_op = alu_f3(Funct3, Funct7[5]);
    end else if (is_ialu) begin
      // only srai uses Funct7[5]; addi must never turn into sub
      alu_op = alu_f3(Funct3, (Funct3 == 3'b101) & Funct7[5]);
      ext_op = 3'b001;
    end else if (is_lui) begin
      alu_op = A_LUI;
      ext_op = 3'b100;
    end else if (is_auipc) begin
      alu_op = A_AUIPC;
      ext_op = 3'b100;
    end else if (is_jal) begin
      ext_op = 3'b101;
    end else if (is_jalr || is_load) begin
      alu_op = A_ADD;
      ext_op = 3'b001;
    end else if (is_store) begin
      alu_op = A_ADD;
      ext_op = 3'b010;
    end else if (is_branch) begin
      ext_op = 3'b011;
      case (Funct3[2:1])
        2'b10:   alu_op = A_SLT;
        2'b11:   alu_op = A_SLTU;
        default: alu_op = A_SUB;
      endcase
    end

    alu_src = is_ialu | is_load | is_store | is_jalr;

    case (Funct3)
      3'b000:  dm_type = 3'b011;
      3'b001:  dm_type = 3'b001;
      3'b100:  dm_type = 3'b100;
      3'b101:  dm_type = 3'b010;
      default: dm_type = 3'b000;
    endcase

    // blt/bltu: slt result nonzero -> taken; bge/bgeu: slt result zero -> taken
    case (Funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100,
      3'b110:  br_taken = ~Zero;
      3'b101,
      3'b111:  br_taken = Zero;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
`ifdef CTRL_ILLEGAL_EN
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
`else
      S_DECODE: state_d = S_EXEC;
`endif
      S_EXEC: begin
        if (is_load || is_store)
          state_d = S_MEM;
        else if (is_r || is_ialu || is_lui || is_auipc || is_jal || is_jalr)
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    illegal  = 1'b0;
    ALUOp    = '0;
    EXTOp    = 3'b000;
    NPCOp    = 3'b000;
    DMType   = '0;
    WDSel    = 2'b00;
    // rst gates everything combinationally so nothing leaks while held in reset
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
        end
        S_DECODE: EXTOp = ext_op;
        S_EXEC: begin
          ALUOp  = ALUOP_W'(alu_op);
          ALUSrc = alu_src;
          EXTOp  = ext_op;
          if (is_branch) begin
            PCWrite = 1'b1;
            NPCOp   = br_taken ? 3'b001 : 3'b000;
          end else if (!is_legal) begin
            PCWrite = 1'b1;
          end
        end
        S_MEM: begin
          ALUOp    = ALUOP_W'(alu_op);
          ALUSrc   = alu_src;
          EXTOp    = ext_op;
          DMType   = DMTYPE_W'(dm_type);
          MemRead  = is_load;
          MemWrite = is_store;
          PCWrite  = is_store & mem_ready;
        end
        S_WB: begin
          ALUOp    = ALUOP_W'(alu_op);
          ALUSrc   = alu_src;
          EXTOp    = ext_op;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          if (is_load) DMType = DMTYPE_W'(dm_type);
          if (is_jal)       NPCOp = 3'b010;
          else if (is_jalr) NPCOp = 3'b100;
          if (is_load)                WDSel = 2'b01;
          else if (is_jal || is_jalr) WDSel = 2'b10;
        end
`ifdef CTRL_ILLEGAL_EN
        S_HALT: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
    retire = PCWrite;
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; per-cycle state/enable checks against hand-computed vectors.
// Enable vector order in checks: {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, retire}.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc, retire, illegal;
  logic [4:0] ALUOp;
  logic [2:0] EXTOp, NPCOp, DMType, state;
  logic [1:0] WDSel;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .retire(retire), .illegal(illegal),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .NPCOp(NPCOp), .DMType(DMType),
    .WDSel(WDSel), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] aluop;
    logic [2:0] ext;
    logic       src;
    logic [2:0] npc;
    logic [1:0] wd;
  } alu_vec_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [2:0] st, input logic [5:0] en);
    #1;
    chk({tag, ".st"}, 32'(state), 32'(st));
    chk({tag, ".en"}, 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, retire}), 32'(en));
  endtask

  function automatic logic [31:0] all_out();
    return 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc, retire, illegal,
                ALUOp, EXTOp, NPCOp, DMType, WDSel, state});
  endfunction

  function automatic alu_vec_t vec(input int i);
    case (i)
      0:  vec = '{7'b0110011, 3'b000, 7'b0000000, 5'b00011, 3'b000, 1'b0, 3'b000, 2'b00}; // add
      1:  vec = '{7'b0110011, 3'b000, 7'b0100000, 5'b00100, 3'b000, 1'b0, 3'b000, 2'b00}; // sub
      2:  vec = '{7'b0110011, 3'b101, 7'b0100000, 5'b01010, 3'b000, 1'b0, 3'b000, 2'b00}; // sra
      3:  vec = '{7'b0110011, 3'b111, 7'b0000000, 5'b01100, 3'b000, 1'b0, 3'b000, 2'b00}; // and
      4:  vec = '{7'b0110011, 3'b100, 7'b0000000, 5'b01000, 3'b000, 1'b0, 3'b000, 2'b00}; // xor
      5:  vec = '{7'b0010011, 3'b000, 7'b0100000, 5'b00011, 3'b001, 1'b1, 3'b000, 2'b00}; // addi, f7 ignored
      6:  vec = '{7'b0010011, 3'b101, 7'b0100000, 5'b01010, 3'b001, 1'b1, 3'b000, 2'b00}; // srai
      7:  vec = '{7'b0010011, 3'b101, 7'b0000000, 5'b01001, 3'b001, 1'b1, 3'b000, 2'b00}; // srli
      8:  vec = '{7'b0010011, 3'b011, 7'b0000000, 5'b00111, 3'b001, 1'b1, 3'b000, 2'b00}; // sltiu
      9:  vec = '{7'b0010011, 3'b110, 7'b0000000, 5'b01011, 3'b001, 1'b1, 3'b000, 2'b00}; // ori
      10: vec = '{7'b0110111, 3'b000, 7'b0000000, 5'b00001, 3'b100, 1'b0, 3'b000, 2'b00}; // lui
      11: vec = '{7'b0010111, 3'b000, 7'b0000000, 5'b00010, 3'b100, 1'b0, 3'b000, 2'b00}; // auipc
      12: vec = '{7'b1101111, 3'b000, 7'b0000000, 5'b00000, 3'b101, 1'b0, 3'b010, 2'b10}; // jal
      default: vec = '{7'b1100111, 3'b000, 7'b0000000, 5'b00011, 3'b001, 1'b1, 3'b100, 2'b10}; // jalr
    endcase
  endfunction

  // F, D, E, WB with mem_ready=1: 4 cycles
  task automatic run_alu(input string tag, input alu_vec_t v);
    Op = v.op; Funct3 = v.f3; Funct7 = v.f7; mem_ready = 1'b1;
    look({tag, ".F"}, 3'd0, 6'b011000);
    tick();
    look({tag, ".D"}, 3'd1, 6'b000000);
    chk({tag, ".D.ext"}, 32'(EXTOp), 32'(v.ext));
    tick();
    look({tag, ".E"}, 3'd2, 6'b000000);
    chk({tag, ".E.alu"}, 32'(ALUOp), 32'(v.aluop));
    chk({tag, ".E.src"}, 32'(ALUSrc), 32'(v.src));
    tick();
    look({tag, ".W"}, 3'd4, 6'b100011);
    chk({tag, ".W.npc"}, 32'(NPCOp), 32'(v.npc));
    chk({tag, ".W.wd"}, 32'(WDSel), 32'(v.wd));
    tick();
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                        input logic [4:0] exp_alu, input logic [2:0] exp_npc);
    Op = 7'b1100011; Funct3 = f3; Funct7 = 7'd0; Zero = z; mem_ready = 1'b1;
    look({tag, ".F"}, 3'd0, 6'b011000);
    tick();
    look({tag, ".D"}, 3'd1, 6'b000000);
    chk({tag, ".D.ext"}, 32'(EXTOp), 32'd3);
    tick();
    look({tag, ".E"}, 3'd2, 6'b100001);
    chk({tag, ".E.alu"}, 32'(ALUOp), 32'(exp_alu));
    chk({tag, ".E.npc"}, 32'(NPCOp), 32'(exp_npc));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Op = 7'd0; Funct3 = 3'd0; Funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.st", 32'(state), 32'd0);
    chk("rst.outs", all_out(), 32'd0);
    rst = 1'b0;

    // fetch stall: MemRead held, no IRWrite
    mem_ready = 1'b0;
    look("fstall0", 3'd0, 6'b001000);
    tick();
    look("fstall1", 3'd0, 6'b001000);
    tick();

    for (int i = 0; i < 14; i++) run_alu($sformatf("alu%0d", i), vec(i));

    // lw with two wait cycles in MEM: 7 cycles total
    Op = 7'b0000011; Funct3 = 3'b010; mem_ready = 1'b1;
    look("lw.F", 3'd0, 6'b011000);
    tick();
    look("lw.D", 3'd1, 6'b000000);
    chk("lw.D.ext", 32'(EXTOp), 32'd1);
    tick();
    look("lw.E", 3'd2, 6'b000000);
    chk("lw.E.alu", 32'(ALUOp), 32'd3);
    chk("lw.E.src", 32'(ALUSrc), 32'd1);
    tick();
    mem_ready = 1'b0;
    look("lw.M0", 3'd3, 6'b001000);
    chk("lw.M0.dm", 32'(DMType), 32'd0);
    tick();
    look("lw.M1", 3'd3, 6'b001000);
    tick();
    mem_ready = 1'b1;
    look("lw.M2", 3'd3, 6'b001000);
    tick();
    look("lw.W", 3'd4, 6'b100011);
    chk("lw.W.wd", 32'(WDSel), 32'd1);
    chk("lw.W.npc", 32'(NPCOp), 32'd0);
    tick();

    run_br("bne_z0", 3'b001, 1'b0, 5'b00100, 3'b001);
    run_br("bge_z0", 3'b101, 1'b0, 5'b00110, 3'b000);
    run_br("beq_z1", 3'b000, 1'b1, 5'b00100, 3'b001);
    run_br("beq_z0", 3'b000, 1'b0, 5'b00100, 3'b000);
    run_br("bltu_z0", 3'b110, 1'b0, 5'b00111, 3'b001);
    run_br("bgeu_z1", 3'b111, 1'b1, 5'b00111, 3'b001);

    // sb with one wait cycle, then straight back to FETCH
    Op = 7'b0100011; Funct3 = 3'b000; mem_ready = 1'b1;
    look("sb.F", 3'd0, 6'b011000);
    tick();
    look("sb.D", 3'd1, 6'b000000);
    chk("sb.D.ext", 32'(EXTOp), 32'd2);
    tick();
    look("sb.E", 3'd2, 6'b000000);
    chk("sb.E.src", 32'(ALUSrc), 32'd1);
    tick();
    mem_ready = 1'b0;
    look("sb.M0", 3'd3, 6'b000100);
    tick();
    mem_ready = 1'b1;
    look("sb.M1", 3'd3, 6'b100101);
    chk("sb.M1.dm", 32'(DMType), 32'd3);
    chk("sb.M1.npc", 32'(NPCOp), 32'd0);
    tick();

    run_alu("jalr", vec(13));

    // unlisted opcode
    Op = 7'b1111111; Funct3 = 3'b000;
    look("ill.F", 3'd0, 6'b011000);
    tick();
    look("ill.D", 3'd1, 6'b000000);
    tick();
`ifdef CTRL_ILLEGAL_EN
    for (int i = 0; i < 10; i++) begin
      look($sformatf("halt%0d", i), 3'd5, 6'b000000);
      chk($sformatf("halt%0d.ill", i), 32'(illegal), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("halt.rst.outs", all_out(), 32'd0);
    tick();
    rst = 1'b0;
    look("halt.exit", 3'd0, 6'b011000);
    chk("halt.exit.ill", 32'(illegal), 32'd0);
`else
    look("ill.E", 3'd2, 6'b100001);
    chk("ill.E.npc", 32'(NPCOp), 32'd0);
    chk("ill.E.ill", 32'(illegal), 32'd0);
    chk("ill.E.alu", 32'(ALUOp), 32'd0);
    tick();
`endif

    // reset in the middle of a load's MEM wait
    Op = 7'b0000011; Funct3 = 3'b010; mem_ready = 1'b1;
    look("rl.F", 3'd0, 6'b011000);
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    look("rl.M", 3'd3, 6'b001000);
    rst = 1'b1;
    #1;
    chk("rl.rst.outs", all_out(), 32'd0);
    tick();
    chk("rl.hold.outs", all_out(), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    look("rl.post.F", 3'd0, 6'b011000);
    tick();
    look("rl.post.D", 3'd1, 6'b000000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
